// File: rtl/fsb8_mem_target.sv
// fsb8_mem_target: FSB8 bus slave that turns address/data/handshake phases into a
// synchronous single-port 8-bit memory interface (single and auto-increment block beats,
// WAIT_CYC wait states per beat).
// Ports: i_clk/i_rst_n (async active-low reset); FSB8 side i_ale_n, i_cs_n, i_cmd_n,
// i_typ, i_wr_n, i_aah8, i_ad_in, o_ad_out, o_ad_oe, o_rdy_n, o_irq_n; memory side
// o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, i_mem_rdata.
// Optional doorbell register at DOORBELL_ADDR: define FSB8_TGT_DOORBELL_EN.
module fsb8_mem_target #(
    parameter int          ADDR_WID      = 16,
    parameter int          WAIT_CYC      = 1,
    parameter logic [15:0] DOORBELL_ADDR = 16'hFFFF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ale_n,
    input  logic                i_cs_n,
    input  logic                i_cmd_n,
    input  logic                i_typ,
    input  logic                i_wr_n,
    output logic                o_rdy_n,
    output logic                o_irq_n,
    input  logic [7:0]          i_aah8,
    input  logic [7:0]          i_ad_in,
    output logic [7:0]          o_ad_out,
    output logic                o_ad_oe,
    output logic [ADDR_WID-1:0] o_mem_addr,
    output logic [7:0]          o_mem_wdata,
    output logic                o_mem_we,
    output logic                o_mem_re,
    input  logic [7:0]          i_mem_rdata
);
`ifdef FSB8_TGT_DOORBELL_EN
    localparam logic DB_EN = 1'b1;
`else
    localparam logic DB_EN = 1'b0;
`endif
    localparam logic [ADDR_WID-1:0] DB_ADDR = DOORBELL_ADDR[ADDR_WID-1:0];
    localparam logic [3:0]          WAIT_LD = 4'(WAIT_CYC);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT, S_ACK, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [ADDR_WID-1:0] r_addr;
    logic                r_rd, r_blk, r_irq_n;
    logic [3:0]          r_cnt;
    logic [7:0]          r_ad_out, r_db;
    logic [15:0]         w_ale_addr;
    logic                w_db_hit;

    assign w_ale_addr  = {i_aah8, i_ad_in};
    assign w_db_hit    = DB_EN && (r_addr == DB_ADDR);
    assign o_ad_out    = r_ad_out;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = i_ad_in;
    assign o_irq_n     = r_irq_n;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    // Deasserting cs_n aborts from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !i_ale_n ? S_ARMED : S_IDLE;
            S_ARMED: w_next = !i_cmd_n ? S_WAIT : S_ARMED;
            S_WAIT:  w_next = (r_cnt <= 4'd1) ? S_ACK : S_WAIT;
            S_ACK:   w_next = r_blk ? S_ARMED : S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (i_cs_n) w_next = S_IDLE;
    end

    // Read data is only valid after the first WAIT cycle, so the driver holds off until then.
    always_comb begin
        o_rdy_n  = !(r_state == S_ACK && !i_cs_n);
        o_mem_we = r_state == S_ACK && !r_rd && !w_db_hit;
        o_mem_re = r_state == S_ARMED && !i_cmd_n && !i_cs_n && r_rd && !w_db_hit;
        o_ad_oe  = r_rd && !i_cs_n && i_ale_n &&
                   (r_state == S_ACK || (r_state == S_WAIT && r_cnt != WAIT_LD));
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_blk    <= 1'b0;
            r_cnt    <= '0;
            r_ad_out <= '0;
            r_db     <= '0;
            r_irq_n  <= 1'b1;
        end else begin
            if (r_state == S_IDLE && !i_cs_n && !i_ale_n) begin
                r_addr <= w_ale_addr[ADDR_WID-1:0];
                r_rd   <= i_wr_n;
                r_blk  <= i_typ;
            end
            if (r_state == S_ACK && w_next == S_ARMED)
                r_addr <= r_addr + ADDR_WID'(1);
            if (r_state == S_ARMED && w_next == S_WAIT)
                r_cnt <= WAIT_LD;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 4'd1;
            // First WAIT cycle of a read: memory data from the ARMED-cycle strobe is valid now.
            if (r_state == S_WAIT && r_cnt == WAIT_LD && r_rd)
                r_ad_out <= w_db_hit ? r_db : i_mem_rdata;
            // Doorbell write raises the interrupt, doorbell read clears it; one beat per ACK so they never collide.
            if (r_state == S_ACK && w_db_hit) begin
                if (!r_rd) r_db <= i_ad_in;
                r_irq_n <= r_rd;
            end
        end
endmodule
